// File: rtl/ex_issue_queue.sv
// Execute-stage issue queue: in-order FIFO feeding a combinational fast unit
// or a start/done slow unit, with a registered result stage toward memory.
module ex_issue_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_dec_req,
    output logic            o_dec_ack,
    input  logic [XLEN-1:0] i_dec_pc,
    input  logic [31:0]     i_dec_inst,
    input  logic [7:0]      i_dec_opcode,
    input  logic [4:0]      i_dec_rd,
    input  logic            i_dec_rd_wen,
    input  logic [XLEN-1:0] i_dec_op1,
    input  logic [XLEN-1:0] i_dec_op2,
    input  logic [XLEN-1:0] i_dec_op3,
    input  logic            i_dec_slow,
    input  logic            i_irq_pending,
    input  logic [XLEN-1:0] i_irq_cause,
    input  logic            i_flush,
    output logic [7:0]      o_hd_opcode,
    output logic [XLEN-1:0] o_hd_pc,
    output logic [XLEN-1:0] o_hd_op1,
    output logic [XLEN-1:0] o_hd_op2,
    output logic [XLEN-1:0] o_hd_op3,
    input  logic [XLEN-1:0] i_fu_rd_wdata,
    input  logic            i_fu_pc_jmp,
    input  logic [XLEN-1:0] i_fu_pc_jmpaddr,
    output logic            o_su_start,
    output logic            o_su_irq,
    input  logic            i_su_done,
    output logic            o_su_ack,
    input  logic            i_su_pc_jmp,
    input  logic [XLEN-1:0] i_su_pc_jmpaddr,
    output logic            o_ex_req,
    input  logic            i_ex_ack,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [31:0]     o_ex_inst,
    output logic [4:0]      o_ex_rd,
    output logic            o_ex_rd_wen,
    output logic [XLEN-1:0] o_ex_rd_wdata,
    output logic            o_ex_pc_jmp,
    output logic [XLEN-1:0] o_ex_pc_jmpaddr,
    output logic [XLEN-1:0] o_ex_intr_no
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [7:0]      opcode;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] op3;
        logic            slow;
    } entry_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_SLOW = 1'b1
    } state_t;

    state_t state_q, state_d;

    entry_t      mem [DEPTH];
    entry_t      head, push_e;
    logic [AW:0] wr_ptr, rd_ptr;

    logic empty, full, push, out_free;
    logic dispatch, go_slow, go_fast, slow_done;

    logic [XLEN-1:0] sd_pc, sd_op1, sd_op2, sd_op3, sd_intr;
    logic [31:0]     sd_inst;
    logic [7:0]      sd_opcode;

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign o_dec_ack = rst_n & ~full & ~i_flush;
    assign push      = i_dec_req & o_dec_ack;
    assign out_free  = ~o_ex_req | i_ex_ack;

    assign dispatch  = (state_q == S_RUN) & ~empty & out_free;
    assign go_slow   = dispatch & (i_irq_pending | head.slow);
    assign go_fast   = dispatch & ~go_slow;
    assign slow_done = (state_q == S_SLOW) & i_su_done & out_free;
    assign o_su_ack  = rst_n & slow_done;

    assign push_e = '{
        pc:     i_dec_pc,
        inst:   i_dec_inst,
        opcode: i_dec_opcode,
        rd:     i_dec_rd,
        rd_wen: i_dec_rd_wen,
        op1:    i_dec_op1,
        op2:    i_dec_op2,
        op3:    i_dec_op3,
        slow:   i_dec_slow
    };

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_e;
    end

    // Flush wins over push/pop; a dispatch this cycle still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + PTR_ONE;
            if (dispatch) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:   if (go_slow)   state_d = S_SLOW;
            S_SLOW:  if (slow_done) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        o_hd_opcode = '0;
        o_hd_pc     = '0;
        o_hd_op1    = '0;
        o_hd_op2    = '0;
        o_hd_op3    = '0;
        if (rst_n && state_q == S_SLOW) begin
            o_hd_opcode = sd_opcode;
            o_hd_pc     = sd_pc;
            o_hd_op1    = sd_op1;
            o_hd_op2    = sd_op2;
            o_hd_op3    = sd_op3;
        end else if (rst_n && !empty) begin
            o_hd_opcode = head.opcode;
            o_hd_pc     = head.pc;
            o_hd_op1    = head.op1;
            o_hd_op2    = head.op2;
            o_hd_op3    = head.op3;
        end
    end

    // Side register keeps the slow-unit entry after it leaves the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_pc      <= '0;
            sd_inst    <= '0;
            sd_opcode  <= '0;
            sd_op1     <= '0;
            sd_op2     <= '0;
            sd_op3     <= '0;
            sd_intr    <= '0;
            o_su_start <= 1'b0;
            o_su_irq   <= 1'b0;
        end else begin
            o_su_start <= go_slow;
            if (go_slow) begin
                sd_pc     <= head.pc;
                sd_inst   <= head.inst;
                sd_opcode <= head.opcode;
                sd_op1    <= head.op1;
                sd_op2    <= head.op2;
                sd_op3    <= head.op3;
                sd_intr   <= i_irq_pending ? i_irq_cause : '0;
                o_su_irq  <= i_irq_pending;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ex_req        <= 1'b0;
            o_ex_pc         <= '0;
            o_ex_inst       <= '0;
            o_ex_rd         <= '0;
            o_ex_rd_wen     <= 1'b0;
            o_ex_rd_wdata   <= '0;
            o_ex_pc_jmp     <= 1'b0;
            o_ex_pc_jmpaddr <= '0;
            o_ex_intr_no    <= '0;
        end else if (go_fast) begin
            o_ex_req        <= 1'b1;
            o_ex_pc         <= head.pc;
            o_ex_inst       <= head.inst;
            o_ex_rd         <= head.rd;
            o_ex_rd_wen     <= head.rd_wen;
            o_ex_rd_wdata   <= i_fu_rd_wdata;
            o_ex_pc_jmp     <= i_fu_pc_jmp;
            o_ex_pc_jmpaddr <= i_fu_pc_jmpaddr;
            o_ex_intr_no    <= '0;
        end else if (slow_done) begin
            o_ex_req        <= 1'b1;
            o_ex_pc         <= sd_pc;
            o_ex_inst       <= sd_inst;
            o_ex_rd         <= '0;
            o_ex_rd_wen     <= 1'b0;
            o_ex_rd_wdata   <= '0;
            o_ex_pc_jmp     <= i_su_pc_jmp;
            o_ex_pc_jmpaddr <= i_su_pc_jmpaddr;
            o_ex_intr_no    <= sd_intr;
        end else if (i_ex_ack) begin
            o_ex_req        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_issue_queue.sv
// Bench for ex_issue_queue: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ex_issue_queue;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_dec_req, o_dec_ack;
    logic [XLEN-1:0] i_dec_pc;
    logic [31:0]     i_dec_inst;
    logic [7:0]      i_dec_opcode;
    logic [4:0]      i_dec_rd;
    logic            i_dec_rd_wen;
    logic [XLEN-1:0] i_dec_op1, i_dec_op2, i_dec_op3;
    logic            i_dec_slow, i_irq_pending, i_flush;
    logic [XLEN-1:0] i_irq_cause;
    logic [7:0]      o_hd_opcode;
    logic [XLEN-1:0] o_hd_pc, o_hd_op1, o_hd_op2, o_hd_op3;
    logic [XLEN-1:0] i_fu_rd_wdata, i_fu_pc_jmpaddr;
    logic            i_fu_pc_jmp;
    logic            o_su_start, o_su_irq, i_su_done, o_su_ack, i_su_pc_jmp;
    logic [XLEN-1:0] i_su_pc_jmpaddr;
    logic            o_ex_req, i_ex_ack;
    logic [XLEN-1:0] o_ex_pc;
    logic [31:0]     o_ex_inst;
    logic [4:0]      o_ex_rd;
    logic            o_ex_rd_wen, o_ex_pc_jmp;
    logic [XLEN-1:0] o_ex_rd_wdata, o_ex_pc_jmpaddr, o_ex_intr_no;

    always #5 clk = ~clk;

    // External fast unit: purely combinational from the head fields.
    assign i_fu_rd_wdata   = o_hd_pc + o_hd_op1;
    assign i_fu_pc_jmp     = o_hd_opcode[0];
    assign i_fu_pc_jmpaddr = o_hd_op2 + o_hd_op3;

    ex_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_dec_req(i_dec_req), .o_dec_ack(o_dec_ack),
        .i_dec_pc(i_dec_pc), .i_dec_inst(i_dec_inst),
        .i_dec_opcode(i_dec_opcode), .i_dec_rd(i_dec_rd),
        .i_dec_rd_wen(i_dec_rd_wen),
        .i_dec_op1(i_dec_op1), .i_dec_op2(i_dec_op2), .i_dec_op3(i_dec_op3),
        .i_dec_slow(i_dec_slow), .i_irq_pending(i_irq_pending),
        .i_irq_cause(i_irq_cause), .i_flush(i_flush),
        .o_hd_opcode(o_hd_opcode), .o_hd_pc(o_hd_pc),
        .o_hd_op1(o_hd_op1), .o_hd_op2(o_hd_op2), .o_hd_op3(o_hd_op3),
        .i_fu_rd_wdata(i_fu_rd_wdata), .i_fu_pc_jmp(i_fu_pc_jmp),
        .i_fu_pc_jmpaddr(i_fu_pc_jmpaddr),
        .o_su_start(o_su_start), .o_su_irq(o_su_irq),
        .i_su_done(i_su_done), .o_su_ack(o_su_ack),
        .i_su_pc_jmp(i_su_pc_jmp), .i_su_pc_jmpaddr(i_su_pc_jmpaddr),
        .o_ex_req(o_ex_req), .i_ex_ack(i_ex_ack),
        .o_ex_pc(o_ex_pc), .o_ex_inst(o_ex_inst), .o_ex_rd(o_ex_rd),
        .o_ex_rd_wen(o_ex_rd_wen), .o_ex_rd_wdata(o_ex_rd_wdata),
        .o_ex_pc_jmp(o_ex_pc_jmp), .o_ex_pc_jmpaddr(o_ex_pc_jmpaddr),
        .o_ex_intr_no(o_ex_intr_no)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [7:0]  opc;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] op1, op2, op3;
        logic        slow;
    } ent_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      nm, act, exp, $time);
    endtask

    // Reference model: FIFO contents, result register, slow-unit hold.
    ent_t        m_q[$];
    logic        m_req, m_slow, m_start, m_irq;
    logic [63:0] m_pc, m_wd, m_ja, m_intr, s_pc, s_intr;
    logic [31:0] m_inst, s_inst;
    logic [4:0]  m_rd;
    logic        m_wen, m_jmp;

    task automatic model_reset();
        m_q.delete();
        m_req = 0; m_slow = 0; m_start = 0; m_irq = 0;
        m_pc = 0; m_wd = 0; m_ja = 0; m_intr = 0; s_pc = 0; s_intr = 0;
        m_inst = 0; s_inst = 0; m_rd = 0; m_wen = 0; m_jmp = 0;
    endtask

    task automatic model_step();
        ent_t h, n;
        logic of, load, psh;
        of   = !m_req || i_ex_ack;
        load = 0;
        psh  = i_dec_req && (m_q.size() < DEPTH) && !i_flush;
        m_start = 0;
        if (!m_slow) begin
            if (m_q.size() > 0 && of) begin
                h = m_q.pop_front();
                if (i_irq_pending || h.slow) begin
                    m_slow = 1; m_start = 1; m_irq = i_irq_pending;
                    s_pc = h.pc; s_inst = h.inst;
                    s_intr = i_irq_pending ? i_irq_cause : 64'd0;
                end else begin
                    load = 1;
                    m_pc = h.pc; m_inst = h.inst; m_rd = h.rd; m_wen = h.wen;
                    m_wd = h.pc + h.op1; m_jmp = h.opc[0];
                    m_ja = h.op2 + h.op3; m_intr = 0;
                end
            end
        end else if (i_su_done && of) begin
            load = 1; m_slow = 0;
            m_pc = s_pc; m_inst = s_inst; m_rd = 0; m_wen = 0; m_wd = 0;
            m_jmp = i_su_pc_jmp; m_ja = i_su_pc_jmpaddr; m_intr = s_intr;
        end
        if (load) m_req = 1;
        else if (i_ex_ack) m_req = 0;
        if (i_flush) m_q.delete();
        else if (psh) begin
            n.pc = i_dec_pc; n.inst = i_dec_inst; n.opc = i_dec_opcode;
            n.rd = i_dec_rd; n.wen = i_dec_rd_wen; n.op1 = i_dec_op1;
            n.op2 = i_dec_op2; n.op3 = i_dec_op3; n.slow = i_dec_slow;
            m_q.push_back(n);
        end
    endtask

    // Compare process: inputs still hold the values seen at the last edge.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        else begin
            model_step();
            chk("dec_ack", 64'(o_dec_ack),
                64'((m_q.size() < DEPTH) && !i_flush));
            chk("ex_req", 64'(o_ex_req), 64'(m_req));
            chk("su_start", 64'(o_su_start), 64'(m_start));
            if (m_start) chk("su_irq", 64'(o_su_irq), 64'(m_irq));
            chk("su_ack", 64'(o_su_ack),
                64'(m_slow && i_su_done && (!m_req || i_ex_ack)));
            chk("hd_pc", o_hd_pc,
                m_slow ? s_pc : (m_q.size() > 0 ? m_q[0].pc : 64'd0));
            if (m_req) begin
                chk("ex_pc", o_ex_pc, m_pc);
                chk("ex_inst", 64'(o_ex_inst), 64'(m_inst));
                chk("ex_rd", 64'(o_ex_rd), 64'(m_rd));
                chk("ex_rd_wen", 64'(o_ex_rd_wen), 64'(m_wen));
                chk("ex_rd_wdata", o_ex_rd_wdata, m_wd);
                chk("ex_pc_jmp", 64'(o_ex_pc_jmp), 64'(m_jmp));
                chk("ex_jmpaddr", o_ex_pc_jmpaddr, m_ja);
                chk("ex_intr_no", o_ex_intr_no, m_intr);
            end
        end
    end

    // External slow unit: countdown after start, done held until ack.
    logic        su_acked = 1'b0;
    int          dev_delay = -1;
    bit          dev_fix = 0;
    bit          dev_busy = 0;
    int          dev_cnt = 0;
    logic [63:0] dev_pc = '0;

    always @(posedge clk) su_acked <= o_su_ack;

    task automatic dev_step();
        if (su_acked) i_su_done = 0;
        if (o_su_start) begin
            dev_busy = 1;
            dev_cnt = (dev_delay < 0) ? int'($urandom_range(0, 4)) : dev_delay;
            dev_pc = o_hd_pc;
        end else if (dev_busy) begin
            if (dev_cnt == 0) begin
                dev_busy = 0;
                i_su_done = 1;
                i_su_pc_jmp = dev_fix ? 1'b1 : 1'($urandom_range(0, 1));
                i_su_pc_jmpaddr = dev_fix ? 64'h8000_0000 : dev_pc + 64'h100;
            end else dev_cnt--;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        dev_step();
    endtask

    task automatic push(input logic [63:0] pc, input logic slow,
                        input logic wen);
        i_dec_req = 1; i_dec_pc = pc; i_dec_inst = pc[31:0] ^ 32'h13;
        i_dec_opcode = 8'h13; i_dec_rd = 5'd3; i_dec_rd_wen = wen;
        i_dec_op1 = 64'd1; i_dec_op2 = pc; i_dec_op3 = 64'd4;
        i_dec_slow = slow;
    endtask

    task automatic idle(input int n);
        i_dec_req = 0; i_flush = 0; i_irq_pending = 0; i_ex_ack = 1;
        repeat (n) tick();
    endtask

    int          starts, nres;
    logic        irq_seen;
    logic [63:0] r_pc[8], r_ja[8], r_intr[8], r_wd[8];
    logic        r_wen[8], r_jmp[8], r_req[8];
    logic        acc[4];

    task automatic obs_clear();
        starts = 0; nres = 0; irq_seen = 0;
    endtask

    task automatic obs();
        if (o_su_start) begin starts++; irq_seen = o_su_irq; end
        if (o_ex_req && nres < 8) begin
            r_pc[nres] = o_ex_pc; r_wen[nres] = o_ex_rd_wen;
            r_jmp[nres] = o_ex_pc_jmp; r_ja[nres] = o_ex_pc_jmpaddr;
            r_intr[nres] = o_ex_intr_no; r_wd[nres] = o_ex_rd_wdata;
            nres++;
        end
    endtask

    initial begin
        i_dec_req = 0; i_dec_pc = 0; i_dec_inst = 0; i_dec_opcode = 0;
        i_dec_rd = 0; i_dec_rd_wen = 0; i_dec_op1 = 0; i_dec_op2 = 0;
        i_dec_op3 = 0; i_dec_slow = 0; i_irq_pending = 0; i_irq_cause = 0;
        i_flush = 0; i_su_done = 0; i_su_pc_jmp = 0; i_su_pc_jmpaddr = 0;
        i_ex_ack = 1;

        // Reset state
        tick(); tick();
        chk("rst_dec_ack", 64'(o_dec_ack), 64'd0);
        chk("rst_ex_req", 64'(o_ex_req), 64'd0);
        chk("rst_hd_pc", o_hd_pc, 64'd0);
        rst_n = 1;
        #1;
        chk("post_rst_dec_ack", 64'(o_dec_ack), 64'd1);
        chk("post_rst_su_start", 64'(o_su_start), 64'd0);
        chk("post_rst_ex_pc", o_ex_pc, 64'd0);
        idle(2);

        // Fast back-to-back
        for (int k = 0; k < 6; k++) begin
            if (k < 3) push(64'h1000 + 64'(4 * k), 0, 1);
            else i_dec_req = 0;
            tick();
            r_req[k] = o_ex_req; r_pc[k] = o_ex_pc; r_wd[k] = o_ex_rd_wdata;
        end
        chk("b2b_req0", 64'(r_req[0]), 64'd0);
        chk("b2b_req1", 64'(r_req[1]), 64'd1);
        chk("b2b_req2", 64'(r_req[2]), 64'd1);
        chk("b2b_req3", 64'(r_req[3]), 64'd1);
        chk("b2b_req4", 64'(r_req[4]), 64'd0);
        chk("b2b_pc0", r_pc[1], 64'h1000);
        chk("b2b_pc1", r_pc[2], 64'h1004);
        chk("b2b_pc2", r_pc[3], 64'h1008);
        chk("b2b_wd0", r_wd[1], 64'h1001);
        chk("b2b_wd1", r_wd[2], 64'h1005);
        chk("b2b_wd2", r_wd[3], 64'h1009);
        idle(3);

        // Back-pressure
        i_ex_ack = 0;
        for (int k = 0; k < 4; k++) begin
            push(64'h4000 + 64'(4 * k), 0, 1);
            #1;
            acc[k] = o_dec_ack;
            tick();
        end
        i_dec_req = 0;
        tick(); tick();
        chk("bp_acc0", 64'(acc[0]), 64'd1);
        chk("bp_acc1", 64'(acc[1]), 64'd1);
        chk("bp_acc2", 64'(acc[2]), 64'd1);
        chk("bp_acc3", 64'(acc[3]), 64'd0);
        chk("bp_full_ack", 64'(o_dec_ack), 64'd0);
        chk("bp_hold_req", 64'(o_ex_req), 64'd1);
        chk("bp_hold_pc", o_ex_pc, 64'h4000);
        i_ex_ack = 1;
        tick();
        chk("bp_ack_back", 64'(o_dec_ack), 64'd1);
        chk("bp_drain1", o_ex_pc, 64'h4004);
        tick();
        chk("bp_drain2", o_ex_pc, 64'h4008);
        idle(3);

        // Exception path
        dev_delay = 5; dev_fix = 1; obs_clear();
        push(64'h2000, 1, 1); tick(); obs();
        push(64'h2004, 0, 1); tick(); obs();
        i_dec_req = 0;
        repeat (25) begin tick(); obs(); end
        chk("exc_starts", 64'(starts), 64'd1);
        chk("exc_nres", 64'(nres), 64'd2);
        chk("exc_pc", r_pc[0], 64'h2000);
        chk("exc_wen", 64'(r_wen[0]), 64'd0);
        chk("exc_jmp", 64'(r_jmp[0]), 64'd1);
        chk("exc_ja", r_ja[0], 64'h8000_0000);
        chk("exc_intr", r_intr[0], 64'd0);
        chk("exc_next_pc", r_pc[1], 64'h2004);
        chk("exc_next_wen", 64'(r_wen[1]), 64'd1);
        dev_delay = -1; dev_fix = 0;
        idle(3);

        // Timer interrupt
        obs_clear();
        i_irq_pending = 1; i_irq_cause = 64'd7;
        push(64'h3000, 0, 1); tick(); obs();
        i_dec_req = 0; tick(); obs();
        i_irq_pending = 0;
        repeat (15) begin tick(); obs(); end
        chk("irq_starts", 64'(starts), 64'd1);
        chk("irq_su_irq", 64'(irq_seen), 64'd1);
        chk("irq_nres", 64'(nres), 64'd1);
        chk("irq_pc", r_pc[0], 64'h3000);
        chk("irq_intr", r_intr[0], 64'd7);
        chk("irq_wen", 64'(r_wen[0]), 64'd0);
        idle(3);

        // Flush during slow
        dev_delay = 8; obs_clear();
        push(64'h5000, 1, 1); tick(); obs();
        push(64'h5004, 0, 1); tick(); obs();
        push(64'h5008, 0, 1); tick(); obs();
        i_dec_req = 0; i_flush = 1; tick(); obs();
        i_flush = 0;
        chk("fl_hd_pc", o_hd_pc, 64'h5000);
        repeat (20) begin tick(); obs(); end
        chk("fl_starts", 64'(starts), 64'd1);
        chk("fl_nres", 64'(nres), 64'd1);
        chk("fl_pc", r_pc[0], 64'h5000);
        dev_delay = -1;
        idle(3);

        // Reset mid-stream
        push(64'h6000, 0, 1); tick();
        push(64'h6004, 0, 1); tick();
        i_dec_req = 0; rst_n = 0;
        #1;
        chk("mrst_ex_req", 64'(o_ex_req), 64'd0);
        chk("mrst_dec_ack", 64'(o_dec_ack), 64'd0);
        tick();
        rst_n = 1;
        #1;
        chk("mrst_ack_after", 64'(o_dec_ack), 64'd1);
        chk("mrst_empty", o_hd_pc, 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mrst_no_req", 64'(o_ex_req), 64'd0);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            i_dec_req = ($urandom % 4) != 0;
            i_dec_pc = {$urandom, $urandom};
            i_dec_inst = $urandom;
            i_dec_opcode = 8'($urandom);
            i_dec_rd = 5'($urandom);
            i_dec_rd_wen = 1'($urandom);
            i_dec_op1 = {$urandom, $urandom};
            i_dec_op2 = {$urandom, $urandom};
            i_dec_op3 = {$urandom, $urandom};
            i_dec_slow = ($urandom % 5) == 0;
            i_irq_pending = ($urandom % 16) == 0;
            i_irq_cause = {$urandom, $urandom};
            i_flush = ($urandom % 40) == 0;
            i_ex_ack = ($urandom % 4) != 0;
            tick();
        end
        idle(30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_issue_queue.md
# ex_issue_queue

Parametrised execute-stage issue controller. It sits between decode and memory-access in the pipelined core. It buffers up to DEPTH decoded instructions behind a req/ack handshake and dispatches them in order: single-cycle work goes to an external combinational fast unit, while exceptions and timer interrupts go to an external multi-cycle slow unit through a start/done handshake. Results are presented to the next stage from registered outputs that stay stable until acknowledged, with a flush that drops undispatched entries.

## Interface
- XLEN, 64, datapath width for pc, operands, results and interrupt number.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- clk  in  1  clock; one clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_dec_req / o_dec_ack  in/out  1  decode handshake; o_dec_ack = (count<DEPTH) & !i_flush.
- i_dec_pc  in  XLEN; i_dec_inst  in  32; i_dec_opcode  in  8; i_dec_rd  in  5; i_dec_rd_wen  in  1.
- i_dec_op1/op2/op3  in  XLEN  operands.
- i_dec_slow  in  1  instruction needs slow unit (ecall, mret).
- i_irq_pending  in  1  enabled timer interrupt pending (mie & mtie & overflow).
- i_irq_cause  in  XLEN  interrupt number to report.
- i_flush  in  1  drop all FIFO entries not yet dispatched.
- o_hd_opcode  out  8; o_hd_pc  out  XLEN; o_hd_op1/op2/op3  out  XLEN  FIFO head fields (0 when empty).
- i_fu_rd_wdata  in  XLEN; i_fu_pc_jmp  in  1; i_fu_pc_jmpaddr  in  XLEN  fast-unit results, combinational from o_hd_*.
- o_su_start  out  1  one-cycle slow-unit start pulse.
- o_su_irq  out  1  start is an interrupt, not an instruction exception.
- i_su_done  in  1  slow unit finished; held until o_su_ack.
- o_su_ack  out  1.
- i_su_pc_jmp  in  1; i_su_pc_jmpaddr  in  XLEN  slow-unit redirect.
- o_ex_req / i_ex_ack  out/in  1  result handshake.
- o_ex_pc  out  XLEN; o_ex_inst  out  32; o_ex_rd  out  5; o_ex_rd_wen  out  1; o_ex_rd_wdata  out  XLEN.
- o_ex_pc_jmp  out  1; o_ex_pc_jmpaddr  out  XLEN; o_ex_intr_no  out  XLEN.

## Operation
- **FIFO**
  - Read/write pointers are log2(DEPTH)+1 bits, with the MSB as the wrap bit.
  - Full when the indices are equal and the MSBs differ; empty when the pointers are equal.
  - Push on i_dec_req & o_dec_ack.
  - No bypass: an entry is never dispatched in the cycle it is pushed.
- **Output register (OR)**
  - Holds all o_ex_* fields; its valid bit is o_ex_req.
  - `out_free = !o_ex_req | i_ex_ack`.
  - On an ack with no new load, o_ex_req clears to 0. Data fields hold their last value.
- **FSM states: S_RUN, S_SLOW.**
- **S_RUN**, when the FIFO is non-empty and out_free:
  - If `i_irq_pending | head.slow`:
    - Pulse o_su_start; set o_su_irq = i_irq_pending.
    - Latch head pc/inst and `intr = i_irq_pending ? i_irq_cause : 0` into a side register.
    - Pop the head and go to S_SLOW.
  - Otherwise load OR from the head:
    - pc, inst, rd, rd_wen from the head.
    - rd_wdata and pc_jmp/jmpaddr from i_fu_*.
    - o_ex_intr_no = 0; o_ex_req = 1.
    - Pop the head.
- **S_SLOW**
  - o_hd_* continue to show the slow unit's latched pc.
  - When `i_su_done & out_free`:
    - Assert o_su_ack (combinational).
    - Load OR with the side-register pc/inst and intr_no, rd = 0, rd_wen = 0, rd_wdata = 0, and pc_jmp/jmpaddr from i_su_*.
    - Set o_ex_req = 1 and return to S_RUN.
  - No dispatch occurs while in S_SLOW.
- **Interrupt sampling**
  - i_irq_pending is sampled only at dispatch.
  - An interrupt takes precedence over the head instruction. The head is consumed and reported with intr_no, rd_wen = 0.
- **Flush**
  - Pointers reset to empty next edge.
  - Does not touch OR, S_SLOW, or the slow unit. An in-flight slow operation completes normally.
  - A dispatch in the flush cycle still proceeds.
- **Reset** (async, rst_n low): pointers = 0, state = S_RUN, and every output register = 0 (o_ex_* all zero, o_su_start = 0, o_su_irq = 0). Combinational outputs o_dec_ack, o_hd_* and o_su_ack are also 0 during reset.

## Timing
- **Fast path:** a decode handshake at edge t gives o_ex_req = 1 after edge t+1.
  - Latency is 2 cycles from req to valid output.
  - Sustained throughput is 1 instruction/cycle while i_ex_ack is held high.
- **Slow path:** o_su_start is high for exactly 1 cycle, after the dispatch edge.
  - o_ex_req rises on the edge after i_su_done & out_free.
  - Minimum 1 cycle from done to valid output.
- **Back-pressure:** with i_ex_ack = 0, OR and o_ex_* stay constant and the FIFO fills.
  - o_dec_ack drops after DEPTH accepted pushes.
- **Ordering:** o_ex results emerge strictly in push order, including across fast/slow transitions.
- **Simultaneous push and pop at full:** the push is refused, because ack was already 0.

## Test plan
- **Reset mid-stream:** DEPTH=2, push 2 fast instructions, assert rst_n low for 1 cycle → o_ex_req = 0, o_dec_ack = 0 during reset, 1 after, FIFO empty, no o_ex_req for 3 cycles.
- **Fast back-to-back:** i_ex_ack = 1, push pc 0x1000, 0x1004, 0x1008 on consecutive cycles with i_fu_rd_wdata = pc+1 → o_ex_req high for 3 consecutive cycles, starting 2 cycles after the first push, carrying pc 0x1000/0x1004/0x1008 with rd_wdata 0x1001/0x1005/0x1009.
- **Back-pressure:** i_ex_ack = 0, push 4 instructions → 3 accepted (DEPTH + OR), o_dec_ack = 0. Then raise ack → outputs drain in order, and o_dec_ack returns 1 the cycle after the first ack.
- **Exception path:** push ecall at pc 0x2000 with slow = 1, then a fast instruction; slow unit asserts done after 5 cycles with jmpaddr 0x8000_0000 → single o_su_start pulse, then output pc 0x2000, rd_wen = 0, pc_jmp = 1, jmpaddr 0x8000_0000, intr_no = 0, followed by the fast instruction.
- **Timer interrupt:** i_irq_pending = 1, i_irq_cause = 7 at dispatch of a fast instruction at pc 0x3000 → o_su_irq = 1, and the output carries intr_no = 7, rd_wen = 0, pc 0x3000.
- **Flush during slow:** in S_SLOW with 2 entries queued, pulse i_flush → queue empties. The slow result still appears once; no further o_ex_req until new pushes arrive.
